// File: rtl/func_pwl_eval_if.sv
// ---------------------------------------------------------------------------
// func_pwl_eval_if
//
// Bundles every non-clock, non-reset signal of the piecewise-linear function
// evaluator: the sample path, the result path and the table-load port.
//
//   master : the stimulus/checker side (drives samples and table writes,
//            observes results)
//   slave  : the evaluator itself
//
// Signals
//   ce        pipeline clock enable (emulator time-step gate)
//   in_valid  in_x holds a sample this cycle
//   in_x      signed input sample, IN_W bits (14 fractional bits)
//   out_valid out_y holds a result
//   out_y     signed interpolated result, OUT_W bits (16 fractional bits)
//   out_sat   out_y was clamped to the OUT_W signed range
//   tbl_we    table write strobe, honoured regardless of ce
//   tbl_addr  segment index to write
//   tbl_a     segment base value A[i]
//   tbl_b     segment delta B[i] (rise across the full segment)
// ---------------------------------------------------------------------------
interface func_pwl_eval_if #(
  parameter int IN_W     = 18,
  parameter int OUT_W    = 18,
  parameter int SEG_LOG2 = 8
);
  logic                       ce;
  logic                       in_valid;
  logic signed [IN_W-1:0]     in_x;
  logic                       out_valid;
  logic signed [OUT_W-1:0]    out_y;
  logic                       out_sat;
  logic                       tbl_we;
  logic        [SEG_LOG2-1:0] tbl_addr;
  logic signed [OUT_W-1:0]    tbl_a;
  logic signed [OUT_W-1:0]    tbl_b;

  modport master (
    output ce, in_valid, in_x, tbl_we, tbl_addr, tbl_a, tbl_b,
    input  out_valid, out_y, out_sat
  );

  modport slave (
    input  ce, in_valid, in_x, tbl_we, tbl_addr, tbl_a, tbl_b,
    output out_valid, out_y, out_sat
  );
endinterface

// File: rtl/func_pwl_eval.sv
// ---------------------------------------------------------------------------
// func_pwl_eval
//
// Four-stage piecewise-linear function evaluator. The input is clipped to
// [IN_MIN, IN_MAX], mapped onto 2^SEG_LOG2 equal segments, and the result is
// A[idx] + B[idx] * frac / 2^FRAC_W, saturated to OUT_W signed bits.
// Input carries 14 fractional bits and output/table entries 16 fractional
// bits; the datapath itself is plain integer arithmetic.
//
// Ports
//   clk  sole clock
//   rst  synchronous, active-high; clears valid bits, out_y and out_sat.
//        Table contents survive reset.
//   io   func_pwl_eval_if.slave (sample, result and table-load signals)
//
// Timing: a sample accepted on enabled edge n is presented on out_* after
// enabled edge n+3 (four enabled edges including the accepting one). With
// ce=0 every pipeline register holds, so a held out_valid=1 is not a new
// result; consumers qualify on ce & out_valid.
// ---------------------------------------------------------------------------
module func_pwl_eval #(
  parameter int IN_W      = 18,
  parameter int OUT_W     = 18,
  parameter int SEG_LOG2  = 8,
  parameter int FRAC_W    = 10,
  parameter int IN_MIN    = -51472,
  parameter int IN_MAX    = 51472,
  parameter int INV_W     = 166886,
  parameter int INV_SHIFT = 16
) (
  input  logic            clk,
  input  logic            rst,
  func_pwl_eval_if.slave  io
);

  localparam int D_W      = IN_W + 1;
  localparam int INV_BITS = $clog2(INV_W + 1);
  localparam int PROD_W   = D_W + INV_BITS;
  localparam int U_W      = SEG_LOG2 + FRAC_W;
  localparam int MUL_W    = OUT_W + FRAC_W + 1;
  localparam int SUM_W    = MUL_W + 1;
  localparam int N_SEG    = 2 ** SEG_LOG2;

  localparam logic signed [IN_W-1:0]  X_LO   = IN_W'(IN_MIN);
  localparam logic signed [IN_W-1:0]  X_HI   = IN_W'(IN_MAX);
  localparam logic signed [D_W-1:0]   LO_EXT = D_W'(IN_MIN);
  localparam logic        [PROD_W-1:0] INV_K = PROD_W'(INV_W);
  localparam logic        [PROD_W-1:0] P_MAX = PROD_W'(2 ** U_W - 1);
  localparam logic signed [SUM_W-1:0] Y_MAX  =
    {{(SUM_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [SUM_W-1:0] Y_MIN  = ~Y_MAX;

  // Clamp a sample into the configured domain.
  function automatic logic signed [IN_W-1:0] clip_in(
    input logic signed [IN_W-1:0] x
  );
    if (x < X_LO)      clip_in = X_LO;
    else if (x > X_HI) clip_in = X_HI;
    else               clip_in = x;
  endfunction

  // A + floor(B * frac / 2^FRAC_W); the sum width cannot overflow.
  function automatic logic signed [SUM_W-1:0] interp(
    input logic signed [OUT_W-1:0] a,
    input logic signed [OUT_W-1:0] b,
    input logic        [FRAC_W-1:0] f
  );
    logic signed [MUL_W-1:0] bf;
    bf     = MUL_W'(b) * MUL_W'($signed({1'b0, f}));
    interp = SUM_W'(a) + SUM_W'(bf >>> FRAC_W);
  endfunction

  // Clamp to the OUT_W signed range; MSB of the result flags clamping.
  function automatic logic [OUT_W:0] sat_out(
    input logic signed [SUM_W-1:0] v
  );
    if (v > Y_MAX)      sat_out = {1'b1, Y_MAX[OUT_W-1:0]};
    else if (v < Y_MIN) sat_out = {1'b1, Y_MIN[OUT_W-1:0]};
    else                sat_out = {1'b0, v[OUT_W-1:0]};
  endfunction

  // Table storage: {A, B} per segment.
  logic [2*OUT_W-1:0] tbl_mem [0:N_SEG-1];

  logic                      vld_p1_q, vld_p2_q, vld_p3_q, out_valid_q;
  logic        [D_W-1:0]     dist_p1_q;
  logic        [SEG_LOG2-1:0] idx_p2_q;
  logic        [FRAC_W-1:0]  frac_p2_q, frac_p3_q;
  logic        [2*OUT_W-1:0] tbl_rd_p3_q;
  logic signed [OUT_W-1:0]   out_y_q;
  logic                      out_sat_q;

  logic signed [D_W-1:0]     xc_ext;
  logic        [D_W-1:0]     dist_d;
  logic        [PROD_W-1:0]  prod_d;
  logic        [PROD_W-1:0]  p_d;
  logic        [U_W-1:0]     u_d;
  logic        [SEG_LOG2-1:0] idx_d;
  logic        [FRAC_W-1:0]  frac_d;
  logic signed [OUT_W-1:0]   a_d, b_d;
  logic signed [SUM_W-1:0]   r_d;
  logic        [OUT_W:0]     sat_d;

  // ---- S1: clip and offset to a non-negative distance from IN_MIN ----
  assign xc_ext = D_W'(clip_in(io.in_x));
  assign dist_d = $unsigned(xc_ext - LO_EXT);

  // ---- S2: segment mapping, full-width product, top-of-domain clamp ----
  assign prod_d = PROD_W'(dist_p1_q) * INV_K;
  assign p_d    = prod_d >> INV_SHIFT;
  // IN_MAX maps exactly onto 2^U_W; fold it into the last segment.
  assign u_d    = (p_d > P_MAX) ? P_MAX[U_W-1:0] : p_d[U_W-1:0];
  assign idx_d  = u_d[U_W-1:FRAC_W];
  assign frac_d = u_d[FRAC_W-1:0];

  // ---- S4: interpolate and saturate ----
  assign a_d   = $signed(tbl_rd_p3_q[2*OUT_W-1:OUT_W]);
  assign b_d   = $signed(tbl_rd_p3_q[OUT_W-1:0]);
  assign r_d   = interp(a_d, b_d, frac_p3_q);
  assign sat_d = sat_out(r_d);

  // Table port: writes ignore ce; the read sees pre-write contents when it
  // hits the address being written in the same cycle.
  always_ff @(posedge clk) begin
    if (io.tbl_we) begin
      tbl_mem[io.tbl_addr] <= {io.tbl_a, io.tbl_b};
    end
  end

  // Datapath registers: no reset, advance on ce only.
  always_ff @(posedge clk) begin
    if (io.ce) begin
      dist_p1_q   <= dist_d;
      idx_p2_q    <= idx_d;
      frac_p2_q   <= frac_d;
      // ---- S3: registered table read ----
      tbl_rd_p3_q <= tbl_mem[idx_p2_q];
      frac_p3_q   <= frac_p2_q;
    end
  end

  // Valid chain and output registers: reset wins over ce.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      vld_p3_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_sat_q   <= 1'b0;
    end else if (io.ce) begin
      vld_p1_q    <= io.in_valid;
      vld_p2_q    <= vld_p1_q;
      vld_p3_q    <= vld_p2_q;
      out_valid_q <= vld_p3_q;
      out_y_q     <= $signed(sat_d[OUT_W-1:0]);
      // Bubbles never report saturation.
      out_sat_q   <= sat_d[OUT_W] & vld_p3_q;
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.out_y     = out_y_q;
  assign io.out_sat   = out_sat_q;

endmodule

// File: tb/tb_func_pwl_eval.sv
module tb_func_pwl_eval;
  localparam int IN_W     = 18;
  localparam int OUT_W    = 18;
  localparam int SEG_LOG2 = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  func_pwl_eval_if #(.IN_W(IN_W), .OUT_W(OUT_W), .SEG_LOG2(SEG_LOG2)) pif ();

  func_pwl_eval dut (
    .clk (clk),
    .rst (rst),
    .io  (pif)
  );

  typedef struct {
    int x;
    int idx;
    int frac;
    int acc;
    int a;
    int b;
    bit has_want;
    int want_y;
    bit want_sat;
  } txn_t;

  txn_t sbq[$];
  int   mdl_a [256];
  int   mdl_b [256];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   edge_cnt = 0;

  bit cur_hw;
  int cur_wy;
  bit cur_ws;

  task automatic check_val(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", tag, act, exp);
    end
  endtask

  // Reference mapping of a raw sample to segment index and fraction.
  function automatic void map_x(input int x, output int idx, output int frac);
    longint xc, d, p;
    xc = (x < -51472) ? -51472 : ((x > 51472) ? 51472 : x);
    d  = xc + 51472;
    p  = (d * 166886) >> 16;
    if (p > 262143) p = 262143;
    idx  = int'(p >> 10);
    frac = int'(p & 1023);
  endfunction

  function automatic void eval_ref(input int a, input int b, input int frac,
                                   output int y, output bit sat);
    longint r;
    r   = longint'(a) + ((longint'(b) * frac) >>> 10);
    sat = 1'b0;
    if (r > 131071)       begin y = 131071;  sat = 1'b1; end
    else if (r < -131072) begin y = -131072; sat = 1'b1; end
    else                  y = int'(r);
  endfunction

  // Monitor / scoreboard: samples #1 after every rising edge.
  logic              prev_v;
  logic signed [17:0] prev_y;
  logic              prev_s;
  always @(posedge clk) begin
    txn_t t;
    bit   exp_v;
    int   ey;
    bit   es;
    #1;
    if (rst) begin
      sbq.delete();
      check_val("rst_out_valid", longint'(pif.out_valid), 0);
      check_val("rst_out_y", longint'(pif.out_y), 0);
      check_val("rst_out_sat", longint'(pif.out_sat), 0);
    end else if (pif.ce) begin
      edge_cnt++;
      // Table lookup happens on the second enabled edge after acceptance.
      foreach (sbq[i]) begin
        if (sbq[i].acc == edge_cnt - 2) begin
          sbq[i].a = mdl_a[sbq[i].idx];
          sbq[i].b = mdl_b[sbq[i].idx];
        end
      end
      exp_v = (sbq.size() > 0) && (sbq[0].acc == edge_cnt - 3);
      check_val("out_valid", longint'(pif.out_valid), longint'(exp_v));
      if (exp_v) begin
        t = sbq.pop_front();
        eval_ref(t.a, t.b, t.frac, ey, es);
        check_val($sformatf("out_y(x=%0d)", t.x), longint'(pif.out_y), ey);
        check_val($sformatf("out_sat(x=%0d)", t.x), longint'(pif.out_sat), longint'(es));
        if (t.has_want) begin
          check_val($sformatf("spec_y(x=%0d)", t.x), longint'(pif.out_y), t.want_y);
          check_val($sformatf("spec_sat(x=%0d)", t.x), longint'(pif.out_sat), longint'(t.want_sat));
        end
      end
      if (pif.in_valid) begin
        t.x        = int'(pif.in_x);
        map_x(t.x, t.idx, t.frac);
        t.acc      = edge_cnt;
        t.a        = 0;
        t.b        = 0;
        t.has_want = cur_hw;
        t.want_y   = cur_wy;
        t.want_sat = cur_ws;
        sbq.push_back(t);
      end
    end else begin
      check_val("hold_valid", longint'(pif.out_valid), longint'(prev_v));
      check_val("hold_y", longint'(pif.out_y), longint'(prev_y));
      check_val("hold_sat", longint'(pif.out_sat), longint'(prev_s));
    end
    if (pif.tbl_we) begin
      mdl_a[pif.tbl_addr] = int'(pif.tbl_a);
      mdl_b[pif.tbl_addr] = int'(pif.tbl_b);
    end
    prev_v = pif.out_valid;
    prev_y = pif.out_y;
    prev_s = pif.out_sat;
  end

  task automatic drive(input bit c, input bit v, input int x,
                       input bit hw = 1'b0, input int wy = 0, input bit ws = 1'b0);
    @(negedge clk);
    pif.ce       = c;
    pif.in_valid = v;
    pif.in_x     = IN_W'(x);
    pif.tbl_we   = 1'b0;
    cur_hw = hw;
    cur_wy = wy;
    cur_ws = ws;
  endtask

  task automatic tbl_wr(input int addr, input int a, input int b, input bit c);
    @(negedge clk);
    pif.ce       = c;
    pif.in_valid = 1'b0;
    pif.tbl_we   = 1'b1;
    pif.tbl_addr = SEG_LOG2'(addr);
    pif.tbl_a    = OUT_W'(a);
    pif.tbl_b    = OUT_W'(b);
    cur_hw = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    bit ce_pat [6];
    ce_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    rst = 1'b1;
    pif.ce = 1'b0; pif.in_valid = 1'b0; pif.in_x = '0;
    pif.tbl_we = 1'b0; pif.tbl_addr = '0; pif.tbl_a = '0; pif.tbl_b = '0;
    cur_hw = 1'b0; cur_wy = 0; cur_ws = 1'b0;

    // Linear table loaded while in reset.
    for (int i = 0; i < 256; i++) tbl_wr(i, (i - 128) * 512, 512, 1'b0);
    drive(1'b1, 1'b0, 0);
    rst = 1'b0;

    // Centre, domain ends, clipping.
    drive(1'b1, 1'b1, 0,       1'b1, 0,      1'b0);
    drive(1'b1, 1'b1, -51472,  1'b1, -65536, 1'b0);
    drive(1'b1, 1'b1, 51472,   1'b1, 65535,  1'b0);
    drive(1'b1, 1'b1, 131071,  1'b1, 65535,  1'b0);
    drive(1'b1, 1'b1, -131072, 1'b1, -65536, 1'b0);
    idle(6);

    // Output saturation.
    tbl_wr(255, 131000, 1023, 1'b1);
    drive(1'b1, 1'b1, 51472, 1'b1, 131071, 1'b1);
    idle(6);
    tbl_wr(255, 127 * 512, 512, 1'b1);

    // Back-to-back stream under a gated ce pattern.
    for (int k = 0; k < 18; k++) drive(ce_pat[k % 6], 1'b1, -60000 + k * 7000);
    idle(6);

    // Reset with three samples in flight, sample accepted as reset drops.
    drive(1'b1, 1'b1, 1000);
    drive(1'b1, 1'b1, 2000);
    drive(1'b1, 1'b1, -3000);
    drive(1'b1, 1'b0, 0);
    rst = 1'b1;
    drive(1'b1, 1'b0, 0);
    drive(1'b1, 1'b1, 0, 1'b1, 0, 1'b0);
    rst = 1'b0;
    drive(1'b1, 1'b1, 51472, 1'b1, 65535, 1'b0);
    idle(6);

    // Write one cycle before the read: new value seen.
    drive(1'b1, 1'b1, 0, 1'b1, 1000, 1'b0);
    tbl_wr(128, 1000, 512, 1'b1);
    idle(6);
    // Write in the same cycle as the read: old value seen.
    drive(1'b1, 1'b1, 0, 1'b1, 1000, 1'b0);
    drive(1'b1, 1'b0, 0);
    tbl_wr(128, -7, 512, 1'b1);
    idle(6);
    tbl_wr(128, 0, 512, 1'b1);
    drive(1'b1, 1'b1, 0, 1'b1, 0, 1'b0);
    idle(6);

    // Random stream with random ce, bubbles and table rewrites.
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      pif.ce       = ($urandom_range(0, 3) != 0);
      pif.in_valid = ($urandom_range(0, 4) != 0);
      pif.in_x     = IN_W'(int'($urandom_range(0, 262143)) - 131072);
      cur_hw       = 1'b0;
      if ($urandom_range(0, 9) == 0) begin
        pif.tbl_we   = 1'b1;
        pif.tbl_addr = SEG_LOG2'($urandom_range(0, 255));
        pif.tbl_a    = OUT_W'(int'($urandom_range(0, 262143)) - 131072);
        pif.tbl_b    = OUT_W'(int'($urandom_range(0, 262143)) - 131072);
      end else begin
        pif.tbl_we = 1'b0;
      end
    end

    // Drain with a bounded wait.
    drive(1'b1, 1'b0, 0);
    for (int i = 0; i < 50 && sbq.size() > 0; i++) drive(1'b1, 1'b0, 0);
    check_val("drain_empty", longint'(sbq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
